ps2_receiver: RTL
=================

// Module: ps2_receiver
// PURPOSE
//  PS/2 device-to-host receiver. Feeds keyboard_display with one scan-code byte per pulse.
//  - Oversamples the raw ps2_clk/ps2_data pins with the system clk.
//  - Deserialises 11-bit frames and checks start, odd parity and stop.
//  - Buffers good bytes in a small FIFO.
//  - Presents each byte as ps2dis_data plus a 1-cycle ps2dis_recFlag pulse.
// PARAMETERS
//  FIFO_DEPTH   8       byte entries; power of 2, >=2
//  TIMEOUT_CYC  100000  idle clk cycles mid-frame before the frame is abandoned (2 ms @ 50 MHz)
// PORTS
//  clk             in   1  system clock; all logic on posedge
//  rst             in   1  reset; synchronous, active-low
//  ps2_clk         in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data        in   1  raw PS/2 data pin (asynchronous)
//  ps2dis_data     out  8  last delivered scan-code byte; held until the next delivery
//  ps2dis_recFlag  out  1  1-cycle pulse: ps2dis_data is new this cycle
//  overflow        out  1  sticky: a good byte was dropped because the FIFO was full
//  frame_err_cnt   out  8  saturating count of bad or timed-out frames
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//  - All outputs 0. FIFO emptied. Bit counter 0. Timeout counter 0.
//  - Sync flops set to 1, so the idle-high bus produces no false edge.
//  - Reset mid-frame discards the partial frame; no error is counted.
//  Synchronisers:
//  - ps2_clk passes through 3 flops. ps2_data passes through 2 flops.
//  - fall = sync_clk[2] & ~sync_clk[1]. Sample data from the 2nd data flop.
//  Frame FSM, states IDLE and SHIFT:
//  - IDLE: on fall with data==0 -> SHIFT, bit_cnt=1. On fall with data==1 -> stay IDLE (not an error).
//  - SHIFT: each fall shifts bits LSB-first into shreg[9:0] and increments bit_cnt.
//  - On the fall that delivers bit 10 (stop): frame good iff data==1 and ^{d[7:0],parity}==1.
//    Then -> IDLE.
//  - Good frame: push d[7:0] if FIFO not full. If full, drop the byte and set overflow (cleared only by reset).
//  - Bad frame: frame_err_cnt+1, saturating at 8'hFF. Nothing is pushed.
//  - Timeout: in SHIFT, count clk cycles since the last fall.
//    At TIMEOUT_CYC -> IDLE and frame_err_cnt+1. The counter restarts on every fall.
//  FIFO and output:
//  - Circular buffer with wrapping rd/wr pointers and a count, $clog2(FIFO_DEPTH)+1 bits.
//  - Pop when count!=0 and ps2dis_recFlag==0. The pop registers ps2dis_data<=mem[rd] and ps2dis_recFlag<=1.
//  - ps2dis_recFlag falls the next cycle. Peak delivery is 1 byte per 2 cycles, far above the PS/2 rate.
//  - Push and pop in the same cycle are both honoured; count is unchanged.
//    When full, a simultaneous pop frees the slot, so the push is accepted and there is no overflow.
//  - Latency: stop-bit fall strobe at cycle E, FIFO empty -> write at end of E -> ps2dis_recFlag high in E+2.
//  - Byte order is preserved exactly. Multi-byte sequences (E0/F0 prefixes) pass through uninterpreted.
// STRUCTURE
//  - Shared package ps2_pkg holds:
//    - PS2_FRAME_BITS=11
//    - scan constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_LSHIFT=8'h12, PS2_LCTRL=8'h14
//    These constants are also consumed by keyboard_display.
//  - Sub-module ps2_sync_fifo (params WIDTH, DEPTH) with ports push, pop, din, dout, full, empty.
//  - The top level keeps the synchronisers, frame FSM, timeout, error counter and output register.
// TESTING
//  - Send frame 0x1C (start 0, bits 00111000, parity 0, stop 1) at 12.5 kHz
//    -> ps2dis_data=8'h1C, one recFlag pulse, 2 cycles after the stop fall.
//  - Send 0x1C, 0xF0, 0x1C back-to-back -> exactly 3 pulses, in order 1C, F0, 1C; frame_err_cnt=0.
//  - Send 0x16 with parity flipped -> no pulse, frame_err_cnt=1. Next good 0x16 is delivered normally.
//  - Stop 4 bits into a frame and wait TIMEOUT_CYC+2 cycles -> frame_err_cnt=1, FSM in IDLE.
//    A subsequent 0x45 is delivered.
//  - Hold the output pop path disabled (force recFlag) and send FIFO_DEPTH+1 = 9 bytes 0x01..0x09
//    -> overflow=1. After release: 0x01..0x08 delivered, 0x09 lost.
//  - Drive rst=0 for 1 cycle after 5 bits of 0x2B, then send 0x2B
//    -> all outputs 0 after reset; a single 0x2B is delivered; frame_err_cnt=0.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 frame constants, scan codes and frame check.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_LCTRL  = 8'h14;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ps2_state_t;

    // bits[0] = start, bits[8:1] = data LSB first, bits[9] = odd parity
    function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
        return stop && !bits[0] && (^bits[9:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_fifo
//  Description : Single-clock circular FIFO; push while full is accepted
//                only when a pop frees the slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd;
    logic [c_AW-1:0]  r_wr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_receiver
//  Description : Oversampling PS/2 device-to-host receiver with frame check,
//                timeout, byte FIFO and single-cycle delivery strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2dis_data,
    output logic       ps2dis_recFlag,
    output logic       overflow,
    output logic [7:0] frame_err_cnt
);
    localparam int                c_TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        c_STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]        r_sync_clk;
    logic [1:0]        r_sync_data;
    ps2_state_t        r_state;
    logic [3:0]        r_bit_cnt;
    logic [9:0]        r_shreg;
    logic [c_TO_W-1:0] r_to_cnt;

    logic       w_fall;
    logic       w_data;
    logic       w_stop;
    logic       w_good;
    logic       w_timeout;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_dout;

    assign w_fall    = r_sync_clk[2] & ~r_sync_clk[1];
    assign w_data    = r_sync_data[1];
    assign w_stop    = w_fall && (r_state == ST_SHIFT) && (r_bit_cnt == c_STOP_IDX);
    assign w_good    = frame_ok(r_shreg, w_data);
    assign w_timeout = (r_state == ST_SHIFT) && !w_fall && (r_to_cnt == c_TO_LAST);
    assign w_push    = w_stop && w_good;
    // Pop path reads the output strobe itself so delivery is at most every other cycle
    assign w_pop     = !w_empty && !ps2dis_recFlag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync_clk  <= 3'b111;
            r_sync_data <= 2'b11;
        end else begin
            r_sync_clk  <= {r_sync_clk[1:0], ps2_clk};
            r_sync_data <= {r_sync_data[0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_to_cnt      <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (((w_stop && !w_good) || w_timeout) && (frame_err_cnt != 8'hFF)) begin
                frame_err_cnt <= frame_err_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_fall && !w_data) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= 4'd1;
                        r_shreg   <= {w_data, r_shreg[9:1]};
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_to_cnt <= '0;
                        if (r_bit_cnt == c_STOP_IDX) begin
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= '0;
                        end else begin
                            r_shreg   <= {w_data, r_shreg[9:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ps2_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_shreg[8:1]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps2dis_data    <= '0;
            ps2dis_recFlag <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (w_pop) begin
                ps2dis_data    <= w_dout;
                ps2dis_recFlag <= 1'b1;
            end else begin
                ps2dis_recFlag <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
